pipe_shifter: RTL and testbench

// - Parametrised, pipelined barrel shifter for the EX stage; generalises the fixed <<2 branch-offset shifter.
// - Performs SLL/SRL/SRA by variable amount, plus optional ROTR, over a log2 barrel split across PIPE_STAGES registers.
// - Valid/ready handshake with whole-pipe stall and synchronous flush; a tag (dest reg) rides alongside the data.

---
 rtl/pipe_shifter.sv | 155 +++++++++++++++
 tb/tb_pipe_shifter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_shifter.sv
`default_nettype none
// ============================================================================
// pipe_shifter: pipelined log2 barrel shifter (SLL/SRL/SRA/ROTR) with a
// valid/ready handshake, whole-pipe stall and synchronous flush.
// Optional rotate: define PIPE_SHIFTER_ROTATE_EN.
// Revision: 1.0
// ============================================================================
module pipe_shifter #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_W     = 5,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_ill
);

  localparam logic [1:0] c_op_sll  = 2'b00;
  localparam logic [1:0] c_op_srl  = 2'b01;
  localparam logic [1:0] c_op_sra  = 2'b10;
  localparam logic [1:0] c_op_rotr = 2'b11;

  logic               r_valid [PIPE_STAGES];
  logic [WIDTH-1:0]   r_data  [PIPE_STAGES];
  logic [SHAMT_W-1:0] r_shamt [PIPE_STAGES];
  logic [1:0]         r_op    [PIPE_STAGES];
  logic [TAG_W-1:0]   r_tag   [PIPE_STAGES];

  logic               w_src_valid [PIPE_STAGES];
  logic [WIDTH-1:0]   w_src_data  [PIPE_STAGES];
  logic [SHAMT_W-1:0] w_src_shamt [PIPE_STAGES];
  logic [1:0]         w_src_op    [PIPE_STAGES];
  logic [TAG_W-1:0]   w_src_tag   [PIPE_STAGES];
  logic [WIDTH-1:0]   w_nxt_data  [PIPE_STAGES];

  logic w_advance;

  // Apply barrel levels [lo, hi) selected by the shift-amount bits.
  function automatic logic [WIDTH-1:0] f_levels(
    input logic [WIDTH-1:0]   d,
    input logic [SHAMT_W-1:0] sh,
    input logic [1:0]         op,
    input int                 lo,
    input int                 hi
  );
    logic [WIDTH-1:0] v;
    int               n;
    v = d;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (k >= lo && k < hi && sh[k]) begin
        n = 1 << k;
        case (op)
          c_op_sll: v = v << n;
          c_op_srl: v = v >> n;
          c_op_sra: v = $signed(v) >>> n;
          default: begin
`ifdef PIPE_SHIFTER_ROTATE_EN
            v = (v >> n) | (v << (WIDTH - n));
`else
            v = v;
`endif
          end
        endcase
      end
    end
    return v;
  endfunction

  assign out_valid = r_valid[PIPE_STAGES-1];
  assign out_data  = r_data[PIPE_STAGES-1];
  assign out_tag   = r_tag[PIPE_STAGES-1];
  assign w_advance = out_ready | ~out_valid;
  assign in_ready  = w_advance & ~flush;

`ifdef PIPE_SHIFTER_ROTATE_EN
  assign out_ill = 1'b0;
`else
  assign out_ill = r_valid[PIPE_STAGES-1] & (r_op[PIPE_STAGES-1] == c_op_rotr);
`endif

  always_comb begin
    w_src_valid[0] = in_valid;
`ifdef PIPE_SHIFTER_ROTATE_EN
    w_src_data[0]  = in_data;
`else
    // Illegal rotate enters as zero so every later level keeps it zero.
    w_src_data[0]  = (in_op == c_op_rotr) ? '0 : in_data;
`endif
    w_src_shamt[0] = in_shamt;
    w_src_op[0]    = in_op;
    w_src_tag[0]   = in_tag;
    for (int s = 1; s < PIPE_STAGES; s++) begin
      w_src_valid[s] = r_valid[s-1];
      w_src_data[s]  = r_data[s-1];
      w_src_shamt[s] = r_shamt[s-1];
      w_src_op[s]    = r_op[s-1];
      w_src_tag[s]   = r_tag[s-1];
    end
  end

  always_comb begin
    for (int s = 0; s < PIPE_STAGES; s++) begin
      w_nxt_data[s] = '0;
      if (w_src_valid[s]) begin
        w_nxt_data[s] = f_levels(w_src_data[s], w_src_shamt[s], w_src_op[s],
                                 s * SHAMT_W / PIPE_STAGES,
                                 (s == PIPE_STAGES - 1) ? SHAMT_W
                                                        : (s + 1) * SHAMT_W / PIPE_STAGES);
      end
    end
  end

  // Bubbles and flushed slots are zeroed so an invalid output reads as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_valid[s] <= 1'b0;
        r_data[s]  <= '0;
        r_shamt[s] <= '0;
        r_op[s]    <= '0;
        r_tag[s]   <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_valid[s] <= 1'b0;
        r_data[s]  <= '0;
        r_shamt[s] <= '0;
        r_op[s]    <= '0;
        r_tag[s]   <= '0;
      end
    end else if (w_advance) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_valid[s] <= w_src_valid[s];
        r_data[s]  <= w_nxt_data[s];
        r_shamt[s] <= w_src_valid[s] ? w_src_shamt[s] : '0;
        r_op[s]    <= w_src_valid[s] ? w_src_op[s]    : '0;
        r_tag[s]   <= w_src_valid[s] ? w_src_tag[s]   : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_shifter.sv
`default_nettype none
// Bench for pipe_shifter: cycle-level reference model plus directed literal checks.
module tb_pipe_shifter;

  localparam int W  = 32;
  localparam int SW = 5;
  localparam int TW = 5;
  parameter  int P  = 2;
`ifdef PIPE_SHIFTER_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_ill;

  int n_checks = 0;
  int n_errors = 0;

  pipe_shifter #(.WIDTH(W), .SHAMT_W(SW), .PIPE_STAGES(P), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_ill(out_ill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int sh,
                                             input logic [1:0] op);
    logic [2*W-1:0] dd;
    case (op)
      2'b00: return d << sh;
      2'b01: return d >> sh;
      2'b10: return $signed(d) >>> sh;
      default: begin
        if (!ROT) return '0;
        dd = {d, d} >> sh;
        return dd[W-1:0];
      end
    endcase
  endfunction

  // Pipeline as P result slots that all move together whenever the output is free.
  logic          m_v [P];
  logic [W-1:0]  m_d [P];
  logic [TW-1:0] m_t [P];
  logic          m_i [P];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      for (int s = 0; s < P; s++) begin
        m_v[s] <= 1'b0; m_d[s] <= '0; m_t[s] <= '0; m_i[s] <= 1'b0;
      end
    end else if (out_ready || !m_v[P-1]) begin
      m_v[0] <= in_valid;
      m_d[0] <= in_valid ? ref_shift(in_data, int'(in_shamt), in_op) : '0;
      m_t[0] <= in_tag;
      m_i[0] <= in_valid && (in_op == 2'b11) && !ROT;
      for (int s = 1; s < P; s++) begin
        m_v[s] <= m_v[s-1]; m_d[s] <= m_d[s-1]; m_t[s] <= m_t[s-1]; m_i[s] <= m_i[s-1];
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_v[P-1]});
    chk("out_data", {32'd0, out_data}, {32'd0, m_d[P-1]});
    if (m_v[P-1]) chk("out_tag", {59'd0, out_tag}, {59'd0, m_t[P-1]});
    chk("out_ill", {63'd0, out_ill}, {63'd0, m_v[P-1] & m_i[P-1]});
    chk("in_ready", {63'd0, in_ready}, {63'd0, (out_ready | ~m_v[P-1]) & ~flush});
  end

  // Issue one op into an empty pipe and check the literal result P cycles later.
  task automatic send_expect(input string nm, input logic [W-1:0] d, input logic [SW-1:0] sh,
                             input logic [1:0] op, input logic [TW-1:0] tag,
                             input logic [W-1:0] exp_d, input logic exp_ill);
    in_data = d; in_shamt = sh; in_op = op; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (P - 1) @(posedge clk);
    @(negedge clk);
    chk({nm, " valid"}, {63'd0, out_valid}, 64'd1);
    chk({nm, " data"}, {32'd0, out_data}, {32'd0, exp_d});
    chk({nm, " tag"}, {59'd0, out_tag}, {59'd0, tag});
    chk({nm, " ill"}, {63'd0, out_ill}, {63'd0, exp_ill});
    @(posedge clk); #1;
  endtask

  initial begin
    int i;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0;
    in_op = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset out_data", {32'd0, out_data}, 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    send_expect("sll1x2", 32'h0000_0001, 5'd2, 2'b00, 5'd7, 32'h0000_0004, 1'b0);
    send_expect("sra31", 32'h8000_0000, 5'd31, 2'b10, 5'd3, 32'hFFFF_FFFF, 1'b0);
    send_expect("srl31", 32'h8000_0000, 5'd31, 2'b01, 5'd4, 32'h0000_0001, 1'b0);
    send_expect("sra0", 32'h8000_0001, 5'd0, 2'b10, 5'd5, 32'h8000_0001, 1'b0);
    send_expect("sll0", 32'hDEAD_BEEF, 5'd0, 2'b00, 5'd6, 32'hDEAD_BEEF, 1'b0);
    send_expect("sll31", 32'h0000_0003, 5'd31, 2'b00, 5'd8, 32'h8000_0000, 1'b0);
    send_expect("sra4pos", 32'h7000_0000, 5'd4, 2'b10, 5'd9, 32'h0700_0000, 1'b0);
    send_expect("rotr1", 32'h0000_0001, 5'd1, 2'b11, 5'd10,
                ROT ? 32'h8000_0000 : 32'h0, !ROT);

    // Back-to-back ops with a three-cycle output stall in the middle.
    i = 0;
    for (int c = 0; c < 20 && i < 4; c++) begin
      in_valid = 1'b1;
      in_data  = 32'h1111_1111 * (i + 1);
      in_shamt = SW'(i * 3);
      in_op    = 2'(i);
      in_tag   = TW'(i + 1);
      out_ready = !(c >= 2 && c < 5);
      @(negedge clk);
      if (in_ready) i++;
      @(posedge clk); #1;
    end
    chk("stall accepted", 64'(i), 64'd4);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (P + 2) @(posedge clk);
    #1;

    // Flush with ops in flight while a new op is offered.
    in_valid = 1'b1; in_op = 2'b00; in_shamt = 5'd1; in_data = 32'h5; in_tag = 5'd11;
    @(posedge clk); #1 in_tag = 5'd12;
    @(posedge clk); #1 flush = 1'b1; in_tag = 5'd13;
    @(negedge clk);
    chk("flush in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush out_valid+1", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("flush out_valid+2", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Random traffic with a reset pulse in the middle.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 70);
      flush     = ($urandom_range(0, 99) < 3);
      in_data   = $urandom;
      in_shamt  = SW'($urandom_range(0, W - 1));
      in_op     = 2'($urandom_range(0, 3));
      in_tag    = TW'($urandom);
      if (c == 700) begin
        rst_n = 1'b0;
        #1 chk("mid reset out_valid", {63'd0, out_valid}, 64'd0);
      end
      if (c == 702) rst_n = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (P + 2) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
